imul_iterative: RTL and testbench

- Multi-cycle 32-bit integer multiplier; functional unit for the TinyRV1 MUL instruction.
- Sits beside the single-cycle add/eq ALU in the datapath.
- Accepts an operand pair over a val/rdy input stream and returns the low nbits of the product over a val/rdy output stream.
- Iterative shift-add implementation: one partial product per cycle, one transaction in flight at a time.

---
 rtl/imul_iterative.sv | 112 +++++++++++
 tb/tb_imul_iterative.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/imul_iterative.sv
// imul_iterative: multi-cycle shift-add integer multiplier (low nbits of product).
// Operands arrive on a val/rdy input stream and the result leaves on a
// val/rdy output stream.
// Only one transaction is in flight at a time.
// Optional feature macro: IMUL_EARLY_EXIT_EN.
// When it is defined, CALC ends as soon as the remaining multiplier bits are all zero.
//
// Handshake: a transfer happens on a rising edge where val && rdy are both 1.
// A producer holds val and data stable until that edge.
// The rdy outputs never depend on the val inputs.
module imul_iterative #(
    parameter int nbits = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             istream_val,
    output logic             istream_rdy,
    input  logic [nbits-1:0] in0,
    input  logic [nbits-1:0] in1,
    output logic             ostream_val,
    input  logic             ostream_rdy,
    output logic [nbits-1:0] out
);

    localparam int CW = (nbits > 2) ? $clog2(nbits) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(nbits - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [nbits-1:0] a_q, a_d;
    logic [nbits-1:0] b_q, b_d;
    logic [nbits-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_iter;

    // Next-state and datapath: accept in IDLE, one partial product per CALC cycle, hold in DONE
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        last_iter = 1'b0;
        case (state_q)
            IDLE: begin
                if (istream_val && istream_rdy) begin
                    a_d     = in0;
                    b_d     = in1;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (b_q[0]) begin
                    acc_d = acc_q + a_q;
                end
                a_d       = a_q << 1;
                b_d       = b_q >> 1;
                cnt_d     = cnt_q + 1'b1;
                last_iter = (cnt_q == LAST_CNT);
`ifdef IMUL_EARLY_EXIT_EN
                // No multiplier bits left: the remaining iterations would add nothing
                if (b_d == '0) begin
                    last_iter = 1'b1;
                end
`else
`endif
                if (last_iter) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (ostream_rdy) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts any transaction in flight and clears the result
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    // Outputs come from state and accumulator flops only.
    // rst masks rdy so that no accept can happen during reset.
    assign istream_rdy = (state_q == IDLE) && !rst;
    assign ostream_val = (state_q == DONE);
    assign out         = acc_q;

endmodule

// File: tb/tb_imul_iterative.sv
// tb_imul_iterative: directed self-checking bench for imul_iterative (nbits=32).
// Expected latency follows IMUL_EARLY_EXIT_EN when the bench is built with it.
module tb_imul_iterative;

    logic        clk;
    logic        rst;
    logic        istream_val;
    logic        istream_rdy;
    logic [31:0] in0;
    logic [31:0] in1;
    logic        ostream_val;
    logic        ostream_rdy;
    logic [31:0] out;

    int n_cmp = 0;
    int n_err = 0;

    imul_iterative #(.nbits(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .istream_val (istream_val),
        .istream_rdy (istream_rdy),
        .in0         (in0),
        .in1         (in1),
        .ostream_val (ostream_val),
        .ostream_rdy (ostream_rdy),
        .out         (out)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One comparison: count it, and on mismatch count and report it
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Number of rising edges from the accept edge until ostream_val is seen
    function automatic int exp_lat(input logic [31:0] b);
`ifdef IMUL_EARLY_EXIT_EN
        int n;
        n = 1;
        for (int i = 0; i < 32; i++) begin
            if (b[i]) n = i + 1;
        end
        return n;
`else
        return 32;
`endif
    endfunction

    // Present operands (called #1 after an edge), wait for the accept edge, then scramble the inputs
    task automatic accept(input string tag, input logic [31:0] a, input logic [31:0] b);
        in0         = a;
        in1         = b;
        istream_val = 1'b1;
        check({tag, " rdy before accept"}, {31'd0, istream_rdy}, 32'd1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        in0         = $urandom;
        in1         = $urandom;
    endtask

    // Wait (bounded) for ostream_val; the number of edges waited is returned in cyc
    task automatic wait_done(input string tag, output int cyc);
        bit rdy_seen;
        cyc      = 0;
        rdy_seen = 1'b0;
        while (!ostream_val && cyc < 100) begin
            if (istream_rdy) rdy_seen = 1'b1;
            @(posedge clk);
            #1;
            cyc++;
        end
        check({tag, " rdy low in CALC"}, {31'd0, rdy_seen}, 32'd0);
        check({tag, " val"}, {31'd0, ostream_val}, 32'd1);
    endtask

    // Full transaction: accept, check latency and result, then handshake the result out
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp);
        int cyc;
        accept(tag, a, b);
        wait_done(tag, cyc);
        check({tag, " latency"}, cyc, exp_lat(b));
        check({tag, " out"}, out, exp);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
        check({tag, " val after handshake"}, {31'd0, ostream_val}, 32'd0);
        check({tag, " rdy after handshake"}, {31'd0, istream_rdy}, 32'd1);
    endtask

    // Directed stimulus
    initial begin
        int cyc;
        rst         = 1'b1;
        istream_val = 1'b0;
        in0         = '0;
        in1         = '0;
        ostream_rdy = 1'b0;

        // Reset for two cycles, with a pending input offered meanwhile
        istream_val = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("reset rdy", {31'd0, istream_rdy}, 32'd0);
            check("reset val", {31'd0, ostream_val}, 32'd0);
            check("reset out", out, 32'd0);
        end
        istream_val = 1'b0;
        rst         = 1'b0;
        #1;
        check("rdy after reset", {31'd0, istream_rdy}, 32'd1);
        @(posedge clk);
        #1;

        // Basic function and wrap/sign cases
        run_op("3x4",       32'd3,          32'd4,          32'd12);
        run_op("ffx_ff",    32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0001);
        run_op("m3x7",      32'hFFFF_FFFD,  32'd7,          32'hFFFF_FFEB);
        run_op("2p16sq",    32'h0001_0000,  32'h0001_0000,  32'h0000_0000);
        run_op("123x0",     32'd123,        32'd0,          32'd0);
        run_op("123x5",     32'd123,        32'd5,          32'd615);
        run_op("2xmsb",     32'd2,          32'h8000_0000,  32'd0);
        run_op("1x_ff",     32'd1,          32'hFFFF_FFFF,  32'hFFFF_FFFF);

        // Backpressure: hold DONE for 10 cycles while new operands are offered
        accept("bp", 32'h0000_1234, 32'h0000_0010);
        wait_done("bp", cyc);
        check("bp latency", cyc, exp_lat(32'h0000_0010));
        in0         = 32'd5;
        in1         = 32'd6;
        istream_val = 1'b1;
        for (int i = 0; i < 10; i++) begin
            check("bp hold val", {31'd0, ostream_val}, 32'd1);
            check("bp hold out", out, 32'h0001_2340);
            check("bp hold rdy", {31'd0, istream_rdy}, 32'd0);
            @(posedge clk);
            #1;
        end
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;
        check("bp post val", {31'd0, ostream_val}, 32'd0);
        check("bp post rdy", {31'd0, istream_rdy}, 32'd1);
        @(posedge clk);
        #1;
        istream_val = 1'b0;
        in0         = $urandom;
        in1         = $urandom;
        check("bp accepted", {31'd0, istream_rdy}, 32'd0);
        wait_done("5x6", cyc);
        check("5x6 latency", cyc, exp_lat(32'd6));
        check("5x6 out", out, 32'd30);
        ostream_rdy = 1'b1;
        @(posedge clk);
        #1;
        ostream_rdy = 1'b0;

        // Reset on the 10th CALC cycle aborts the transaction
        accept("abort", 32'd6, 32'd7);
        ostream_rdy = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(posedge clk);
            #1;
        end
        ostream_rdy = 1'b0;
`ifndef IMUL_EARLY_EXIT_EN
        check("abort still busy", {31'd0, istream_rdy}, 32'd0);
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort val", {31'd0, ostream_val}, 32'd0);
        check("abort out", out, 32'd0);
        check("abort rdy in rst", {31'd0, istream_rdy}, 32'd0);
        rst = 1'b0;
        #1;
        check("abort idle rdy", {31'd0, istream_rdy}, 32'd1);
        @(posedge clk);
        #1;
        check("abort stays idle", {31'd0, ostream_val}, 32'd0);
        run_op("2x9", 32'd2, 32'd9, 32'd18);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
